// File: rtl/rom_fetch_bridge.sv
// Valid/ready read bridge in front of the 1024x32 single-port instruction ROM macro.
// Requests go to the macro at accept, data is captured a cycle later and returned in order through a small FIFO.
module rom_fetch_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rom_cs,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_dout
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   offset;
    logic          good;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    logic          b_valid_q, b_valid_d;
    logic          b_err_q, b_err_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   fifo_data_q [DEPTH];
    logic          fifo_err_q  [DEPTH];

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
    assign offset   = req_addr - BASE_ADDR;
    assign good     = (offset[31:12] == 20'd0) & ~req_we;
    assign rom_addr = offset[11:2];

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = b_valid_q;

    // Credit counts the entry still in stage B, so the FIFO write it causes can never overflow.
    assign occupancy = {1'b0, count_q} + (CW+1)'(b_valid_q) - (CW+1)'(pop);
    assign req_ready = (occupancy < (CW+1)'(DEPTH));
    assign accept    = req_valid & req_ready;
    assign rom_cs    = accept & good;

    assign rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : 32'd0;
    assign rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

    always_comb begin
        b_valid_d = accept;
        b_err_d   = ~good;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_err_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            b_valid_q <= b_valid_d;
            b_err_q   <= b_err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= b_err_q ? 32'd0 : rom_dout;
            fifo_err_q[wr_ptr_q]  <= b_err_q;
        end
    end

endmodule

// File: tb/tb_rom_fetch_bridge.sv
// Randomised and directed bench for rom_fetch_bridge against a queue-based transaction model
// with a behavioural ROM macro that outputs poison right after the latching edge.
module tb_rom_fetch_bridge;

    localparam logic [31:0] BASE  = 32'h0002_0000;
    localparam int          DEPTH = 2;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rom_cs;
    logic [9:0]  rom_addr;
    logic [31:0] rom_dout;

    rom_fetch_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Macro model: latches cs/addr at posedge, shows poison until the following negedge, then the word.
    logic [31:0] rom_mem [1024];
    logic [9:0]  rom_lat_addr;
    logic        rom_pend;

    always @(posedge clk) begin
        if (rom_cs) begin
            rom_lat_addr <= rom_addr;
            rom_pend     <= 1'b1;
            rom_dout     <= POISON;
        end else begin
            rom_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rom_pend) rom_dout <= rom_mem[rom_lat_addr];
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          avail;
    } rsp_t;

    rsp_t exp_q[$];
    int   cyc;
    int   n_total;
    int   n_bad;
    int   n_rsp;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: starts at a posedge, drives inputs, checks outputs mid-cycle, ends at the next posedge.
    task automatic step(input logic v, input logic [31:0] a, input logic w, input logic rr, output logic acc);
        logic        exp_valid;
        logic        exp_pop;
        logic        exp_ready;
        logic        exp_good;
        logic [31:0] off;
        rsp_t        ent;
        #1;
        req_valid = v;
        req_addr  = a;
        req_we    = w;
        rsp_ready = rr;
        #3;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        exp_pop   = exp_valid & rr;
        exp_ready = ((exp_q.size() - (exp_pop ? 1 : 0)) < DEPTH);
        acc       = v & exp_ready;
        off       = a - BASE;
        exp_good  = (off < 32'd4096) && !w;
        chk_val("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk_val("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
        chk_val("rom_cs", {31'd0, rom_cs}, {31'd0, acc & exp_good});
        if (acc && exp_good) chk_val("rom_addr", {22'd0, rom_addr}, {22'd0, off[11:2]});
        if (exp_valid) begin
            chk_val("rsp_rdata", rsp_rdata, exp_q[0].data);
            chk_val("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
        end
        @(posedge clk);
        if (exp_pop) begin
            $display("rsp %0d: rdata=%h err=%0b", n_rsp, rsp_rdata, rsp_err);
            n_rsp++;
            void'(exp_q.pop_front());
        end
        if (acc) begin
            ent.data  = exp_good ? rom_mem[off[11:2]] : 32'd0;
            ent.err   = !exp_good;
            ent.avail = cyc + 2;
            exp_q.push_back(ent);
        end
        cyc++;
    endtask

    task automatic send(input logic [31:0] a, input logic w);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, a, w, 1'b1, acc);
            tries++;
        end
        chk_val("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        logic acc;
        int   tries;
        tries = 0;
        while (exp_q.size() > 0 && tries < 40) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, acc);
            tries++;
        end
        step(1'b0, 32'd0, 1'b0, 1'b1, acc);
        chk_val("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic reset_pulse();
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk_val("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk_val("rst_rom_cs", {31'd0, rom_cs}, 32'd0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        logic        acc;
        logic [31:0] a;
        logic [31:0] bp_addr [4];
        int          idx;
        int          r;

        n_total = 0;
        n_bad   = 0;
        n_rsp   = 0;
        cyc     = 0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
        rom_mem[5]    = 32'hDEADBEEF;
        rom_mem[1023] = 32'hC0FFEE11;
        rom_dout  = 32'd0;
        rom_pend  = 1'b0;
        rom_lat_addr = 10'd0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_we    = 1'b0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        chk_val("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk_val("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk_val("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk_val("reset_rom_cs", {31'd0, rom_cs}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        // Single read of word 5.
        send(BASE + 32'h14, 1'b0);
        drain();

        // Back-to-back stream of words 0..7.
        for (int i = 0; i < 8; i++) send(BASE + 32'(4 * i), 1'b0);
        drain();

        // Back-pressure: four requests offered, consumer stalled for five cycles.
        for (int i = 0; i < 4; i++) bp_addr[i] = BASE + 32'(4 * (10 + i));
        idx = 0;
        for (int c = 0; c < 30 && (idx < 4 || exp_q.size() > 0); c++) begin
            a = (idx < 4) ? bp_addr[idx] : 32'd0;
            step(idx < 4, a, 1'b0, c >= 5, acc);
            if (acc) idx++;
        end
        chk_val("bp_all_sent", idx, 32'd4);
        drain();

        // Errors sandwiched between good reads.
        send(BASE + 32'h20, 1'b0);
        send(BASE + 32'h1000, 1'b0);
        send(BASE + 32'h24, 1'b0);
        send(BASE + 32'h8, 1'b1);
        send(BASE + 32'h28, 1'b0);
        drain();

        // Boundaries.
        send(BASE + 32'hFFC, 1'b0);
        send(BASE - 32'd4, 1'b0);
        drain();

        // Reset mid-flight with two responses held back.
        step(1'b1, BASE + 32'h30, 1'b0, 1'b0, acc);
        step(1'b1, BASE + 32'h34, 1'b0, 1'b0, acc);
        step(1'b0, 32'd0, 1'b0, 1'b0, acc);
        reset_pulse();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1, acc);
        send(BASE + 32'h14, 1'b0);
        drain();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(0, 3));
            else if (r == 7) a = BASE + 32'h1000 + 32'($urandom_range(0, 65535));
            else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 100));
            else             a = $urandom;
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
